// File: rtl/fetch_queue.sv
// Fetch queue: compacts fetch packets (up to 2 slots) into a circular FIFO and presents 2 in-order entries to decode.
// Optional: define FETCH_QUEUE_PERF_EN to add perf_full_cnt_o (cycles a packet was offered while the queue was full).
module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int PRED_W = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_pc_i,
  input  logic [1:0]            in_mask_i,
  input  logic [63:0]           in_inst_i,
  input  logic [PRED_W-1:0]     in_pred_i,
  output logic [1:0]            out_valid_o,
  output logic [63:0]           out_pc_o,
  output logic [63:0]           out_inst_o,
  output logic [2*PRED_W-1:0]   out_pred_o,
  input  logic [1:0]            out_accept_i
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]           perf_full_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [AW:0]         count_q, count_d;
  logic [31:0]         pc_mem   [DEPTH];
  logic [31:0]         inst_mem [DEPTH];
  logic [PRED_W-1:0]   pred_mem [DEPTH];

  logic                push, wr0_en, wr1_en;
  logic [AW-1:0]       wr1_addr, head_p1;
  logic [1:0]          n_push, n_pop;
  logic                valid0, valid1, pop0, pop1;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^in_pc_i[2:0];

  // Ready is a function of registered occupancy only, so it never combinationally loops back to the BPU.
  assign in_ready_o = (count_q <= READY_MAX);

  assign push     = in_valid_i & in_ready_o & ~flush_i;
  assign wr0_en   = push & in_mask_i[0];
  assign wr1_en   = push & in_mask_i[1];
  assign wr1_addr = in_mask_i[0] ? tail_q + AW'(1) : tail_q;
  assign n_push   = push ? (2'(in_mask_i[0]) + 2'(in_mask_i[1])) : 2'd0;

  assign valid0  = (count_q != '0);
  assign valid1  = (count_q >= (AW+1)'(2));
  assign pop0    = out_accept_i[0] & valid0;
  assign pop1    = out_accept_i[1] & valid1;
  assign n_pop   = 2'(pop0) + 2'(pop1);
  assign head_p1 = head_q + AW'(1);

  always_comb begin
    head_d  = head_q + AW'(n_pop);
    tail_d  = tail_q + AW'(n_push);
    count_d = count_q + (AW+1)'(n_push) - (AW+1)'(n_pop);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      pc_mem[tail_q]   <= {in_pc_i[31:3], 3'b000};
      inst_mem[tail_q] <= in_inst_i[31:0];
      pred_mem[tail_q] <= in_pred_i;
    end
    if (wr1_en) begin
      pc_mem[wr1_addr]   <= {in_pc_i[31:3], 3'b100};
      inst_mem[wr1_addr] <= in_inst_i[63:32];
      pred_mem[wr1_addr] <= in_pred_i;
    end
  end

  assign out_valid_o = {valid1, valid0};
  assign out_pc_o    = {pc_mem[head_p1], pc_mem[head_q]};
  assign out_inst_o  = {inst_mem[head_p1], inst_mem[head_q]};
  assign out_pred_o  = {pred_mem[head_p1], pred_mem[head_q]};

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_full_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_cnt_q <= '0;
    end else if (in_valid_i & ~in_ready_o & ~flush_i) begin
      perf_full_cnt_q <= perf_full_cnt_q + 32'd1;
    end
  end

  assign perf_full_cnt_o = perf_full_cnt_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the branch predictor / icache fetch stage, upstream of decode.
- Accepts one 8-byte-aligned fetch packet per cycle (up to 2 instructions, each tagged with its PC and the BPU prediction metadata).
- Compacts the valid slots into a circular FIFO and presents up to 2 in-order instructions per cycle to decode.
- Backpressures fetch via in_ready_o, which feeds the BPU stall_i. Flushed on redirect.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of 2, >= 4.
- PRED_W, 34, width of opaque prediction metadata per packet (fsc 1 + lphr 2 + lphr_index + spare); carried unmodified.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline redirect; empties queue
- in_valid_i  in  1  fetch packet valid
- in_ready_o  out  1  queue can accept a full packet this cycle
- in_pc_i  in  32  packet base PC; bits [2:0] ignored, slot k PC = {in_pc_i[31:3], k, 2'b00}
- in_mask_i  in  2  slot valid mask; legal values 01, 10, 11
- in_inst_i  in  64  slot0 = [31:0], slot1 = [63:32]
- in_pred_i  in  PRED_W  prediction metadata, copied to every written entry
- out_valid_o  out  2  head entries valid; [1] implies [0]
- out_pc_o  out  64  PCs of head entries (slot0 = oldest)
- out_inst_o  out  64  instructions of head entries
- out_pred_o  out  2*PRED_W  metadata of head entries
- out_accept_i  in  2  decode consumes head entries; legal values 00, 01, 11
- perf_full_cnt_o  out  32  present only with FETCH_QUEUE_PERF_EN

Behaviour:
- State: entry RAM [DEPTH], head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Reset (async): head = tail = count = 0, so out_valid_o = 00 and in_ready_o = 1. Entry contents need no reset.
- in_ready_o = (DEPTH - count) >= 2, computed from registered count only; never depends on in_valid_i or out_accept_i.
- Push fires when in_valid_i & in_ready_o:
  - mask 11: write slot0 at tail and slot1 at tail+1; tail += 2.
  - mask 01: write slot0 only; tail += 1.
  - mask 10: write slot1 only at tail; tail += 1.
  - Illegal mask 00 with valid: nothing written.
- out_valid_o[0] = count >= 1; out_valid_o[1] = count >= 2. Outputs driven combinationally from registered head entries; zero-latency read.
- Pop: head += popcount(out_accept_i & out_valid_o). Accepting an invalid slot is ignored.
- Same-cycle push and pop are allowed: count_next = count + pushed - popped. Data pushed this cycle becomes visible on the next cycle (no bypass). Minimum in-to-out latency is 1 cycle.
- flush_i has priority over push and pop. Next cycle: head = tail = count = 0. Packet and accepts in the flush cycle are discarded.
- Pointer wrap: entry DEPTH-1 is followed by entry 0. A 2-slot write straddling the wrap is legal.
- Full: count = DEPTH-1 or DEPTH deasserts in_ready_o. A same-cycle pop does not re-enable ready until the following cycle.

Optional Feature:
- FETCH_QUEUE_PERF_EN defined: adds perf_full_cnt_o, a 32-bit counter.
  - Increments each cycle in_valid_i & ~in_ready_o & ~flush_i.
  - Reset to 0 by rst_n only, not by flush; wraps at 2^32.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- Reset then idle -> out_valid_o = 00, in_ready_o = 1.
- Push pc 0x1c000000 mask 11 with accept 00 -> next cycle out_valid_o = 11, out_pc_o = {0x1c000004, 0x1c000000}, count = 2.
- Push pc 0x1c000004 mask 10 then pc 0x1c000008 mask 01 -> entries hold PCs 0x1c000004, 0x1c000008 in order, with slot1 then slot0 instructions respectively.
- Fill DEPTH=8 with four mask-11 packets and accept 00 -> in_ready_o = 0 after 3rd packet reaches count 6? No: ready stays 1 at count 6, drops at count 8.
  - Then accept 01 -> count 7, ready still 0.
  - Then accept 11 -> count 5, ready returns 1.
- Continuous push 11 with accept 11 for 20 cycles -> pointers wrap, PCs increment by 8 per cycle in strict order, count constant at 2.
- Count 5 with flush_i, in_valid_i and accept 11 all asserted in the same cycle -> next cycle out_valid_o = 00, in_ready_o = 1, nothing written.
  - With FETCH_QUEUE_PERF_EN: 3 cycles of valid while full -> perf_full_cnt_o = 3.
